// File: rtl/alu_seq_core_pkg.sv
// Shared widths, opcode indices, FSM encoding and small helpers for the sequential signed ALU.
package alu_seq_core_pkg;

  localparam int W_IN  = 8;
  localparam int W_OUT = 16;
  localparam int W_ACC = 24;
  localparam int W_OP  = 5;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;
  localparam int OP_EXP = 4;

  // Largest result magnitudes representable in 16-bit signed, per result sign.
  localparam logic [W_ACC-1:0] R16_MAX_MAG = 24'd32767;
  localparam logic [W_ACC-1:0] R16_MIN_MAG = 24'd32768;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  function automatic logic is_onehot(input logic [W_OP-1:0] op);
    return (op != '0) && ((op & (op - W_OP'(1))) == '0);
  endfunction

  // Magnitude of a signed operand; -128 maps to unsigned 128.
  function automatic logic [W_IN-1:0] mag(input logic signed [W_IN-1:0] v);
    return v[W_IN-1] ? W_IN'(-v) : v;
  endfunction

endpackage

// File: rtl/alu_seq_core_mulstep.sv
// One unsigned shift-add multiply step with a 16-bit signed range check on the running sum.
module alu_seq_core_mulstep
  import alu_seq_core_pkg::*;
(
  input  logic [W_ACC-1:0] acc_i,
  input  logic [W_ACC-1:0] mcand_i,
  input  logic             bit_i,
  input  logic             neg_i,
  output logic [W_ACC-1:0] sum_o,
  output logic             ovf_o
);

  always_comb begin
    sum_o = bit_i ? (acc_i + mcand_i) : acc_i;
    // Magnitudes only grow step to step, so an early trip here is final.
    ovf_o = neg_i ? (sum_o > R16_MIN_MAG) : (sum_o > R16_MAX_MAG);
  end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential signed ALU: ADD/SUB in one pass, MUL/EXP via shared shift-add step, DIV by restoring
// division. Handshake: START is taken when BUSY=0; DONE pulses for one cycle when R/OVF update.
module alu_seq_core
  import alu_seq_core_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic signed [W_IN-1:0]  K,
  input  logic signed [W_IN-1:0]  M,
  input  logic                    ADD,
  input  logic                    SUB,
  input  logic                    MUL,
  input  logic                    DIV,
  input  logic                    EXP,
  output logic                    BUSY,
  output logic                    DONE,
  output logic signed [W_OUT-1:0] R,
  output logic                    OVF,
  output logic [2:0]              state_o
);

  state_t                  state_q;
  logic [W_OP-1:0]         op_q;
  logic signed [W_IN-1:0]  k_q, m_q;
  logic [W_ACC-1:0]        acc_q, mcand_q;
  logic [W_IN-1:0]         mplier_q;
  logic [2:0]              step_q;
  logic [W_IN-2:0]         exp_cnt_q;
  logic                    neg_q;
  logic [W_IN-1:0]         rem_q, quot_q, dvsr_q;
  logic                    fix_direct_q, fix_ovf_q;
  logic [W_OUT-1:0]        fix_val_q;
  logic                    busy_q, done_q, ovf_q;
  logic [W_OUT-1:0]        r_q;

  logic [W_OP-1:0]  op_in;
  logic             prod_neg;
  logic [W_ACC-1:0] step_sum;
  logic             step_ovf;
  logic [W_IN:0]    rem_shift;
  logic             rem_ge;
  logic [W_IN-1:0]  rem_sub;
  logic [W_OUT-1:0] mag_res, fix_res;

  assign op_in    = {EXP, DIV, MUL, SUB, ADD};
  assign prod_neg = neg_q ^ k_q[W_IN-1];

  alu_seq_core_mulstep u_mulstep (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .bit_i   (mplier_q[0]),
    .neg_i   (prod_neg),
    .sum_o   (step_sum),
    .ovf_o   (step_ovf)
  );

  always_comb begin
    rem_shift = {rem_q, quot_q[W_IN-1]};
    rem_ge    = rem_shift >= {1'b0, dvsr_q};
    rem_sub   = rem_shift[W_IN-1:0] - dvsr_q;
    mag_res   = op_q[OP_DIV] ? {{(W_OUT-W_IN){1'b0}}, quot_q} : acc_q[W_OUT-1:0];
    fix_res   = neg_q ? (~mag_res + W_OUT'(1)) : mag_res;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      k_q          <= '0;
      m_q          <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      step_q       <= '0;
      exp_cnt_q    <= '0;
      neg_q        <= 1'b0;
      rem_q        <= '0;
      quot_q       <= '0;
      dvsr_q       <= '0;
      fix_direct_q <= 1'b0;
      fix_ovf_q    <= 1'b0;
      fix_val_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      r_q          <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_FIN: begin
          if (START) begin
            op_q    <= op_in;
            k_q     <= K;
            m_q     <= M;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_LOAD: begin
          // Default path is a direct result resolved here; iterative ops override below.
          fix_direct_q <= 1'b1;
          fix_ovf_q    <= 1'b0;
          fix_val_q    <= '0;
          step_q       <= '0;
          neg_q        <= k_q[W_IN-1] ^ m_q[W_IN-1];
          state_q      <= ST_FIX;
          if (!is_onehot(op_q)) begin
            fix_ovf_q <= 1'b1;
          end else if (op_q[OP_ADD]) begin
            fix_val_q <= {{(W_OUT-W_IN){k_q[W_IN-1]}}, k_q} + {{(W_OUT-W_IN){m_q[W_IN-1]}}, m_q};
          end else if (op_q[OP_SUB]) begin
            fix_val_q <= {{(W_OUT-W_IN){k_q[W_IN-1]}}, k_q} - {{(W_OUT-W_IN){m_q[W_IN-1]}}, m_q};
          end else if (op_q[OP_MUL]) begin
            fix_direct_q <= 1'b0;
            acc_q        <= '0;
            mcand_q      <= W_ACC'(mag(k_q));
            mplier_q     <= mag(m_q);
            state_q      <= ST_ITER;
          end else if (op_q[OP_DIV]) begin
            if (m_q == '0) begin
              fix_ovf_q <= 1'b1;
            end else begin
              fix_direct_q <= 1'b0;
              rem_q        <= '0;
              quot_q       <= mag(k_q);
              dvsr_q       <= mag(m_q);
              state_q      <= ST_ITER;
            end
          end else begin
            if (m_q == '0) begin
              fix_val_q <= W_OUT'(1);
            end else if (m_q[W_IN-1]) begin
              // Negative exponent: only |K|=1 yields a nonzero integer result.
              if (k_q == W_IN'(1))   fix_val_q <= W_OUT'(1);
              else if (k_q == '1)    fix_val_q <= m_q[0] ? '1 : W_OUT'(1);
              else if (k_q == '0)    fix_ovf_q <= 1'b1;
            end else begin
              fix_direct_q <= 1'b0;
              acc_q        <= '0;
              mcand_q      <= W_ACC'(1);
              mplier_q     <= mag(k_q);
              exp_cnt_q    <= m_q[W_IN-2:0];
              neg_q        <= 1'b0;
              state_q      <= ST_ITER;
            end
          end
        end

        ST_ITER: begin
          step_q <= step_q + 3'd1;
          if (op_q[OP_DIV]) begin
            rem_q  <= rem_ge ? rem_sub : rem_shift[W_IN-1:0];
            quot_q <= {quot_q[W_IN-2:0], rem_ge};
            if (step_q == 3'd7) state_q <= ST_FIX;
          end else if (op_q[OP_EXP] && step_ovf) begin
            fix_direct_q <= 1'b1;
            fix_ovf_q    <= 1'b1;
            fix_val_q    <= '0;
            state_q      <= ST_FIX;
          end else begin
            acc_q    <= step_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (step_q == 3'd7) begin
              if (op_q[OP_MUL]) begin
                state_q <= ST_FIX;
              end else begin
                // One EXP factor done: product becomes the next multiplicand.
                neg_q <= prod_neg;
                if (exp_cnt_q == (W_IN-1)'(1)) begin
                  state_q <= ST_FIX;
                end else begin
                  acc_q     <= '0;
                  mcand_q   <= step_sum;
                  mplier_q  <= mag(k_q);
                  exp_cnt_q <= exp_cnt_q - (W_IN-1)'(1);
                end
              end
            end
          end
        end

        ST_FIX: begin
          r_q     <= fix_direct_q ? fix_val_q : fix_res;
          ovf_q   <= fix_direct_q & fix_ovf_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_FIN;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign R       = r_q;
  assign OVF     = ovf_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed-vector bench for alu_seq_core: hand-computed results checked through one compare task.
module tb_alu_seq_core;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_MUL = 5'b00100;
  localparam logic [4:0] OP_DIV = 5'b01000;
  localparam logic [4:0] OP_EXP = 5'b10000;

  logic        clk, rst, start;
  logic [7:0]  k, m;
  logic        op_add, op_sub, op_mul, op_div, op_exp;
  logic        busy, done, ovf;
  logic [15:0] r;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];

  alu_seq_core dut (
    .CLK     (clk),
    .RST     (rst),
    .START   (start),
    .K       (k),
    .M       (m),
    .ADD     (op_add),
    .SUB     (op_sub),
    .MUL     (op_mul),
    .DIV     (op_div),
    .EXP     (op_exp),
    .BUSY    (busy),
    .DONE    (done),
    .R       (r),
    .OVF     (ovf),
    .state_o (state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [4:0] op, input int ka, input int mb);
    {op_exp, op_div, op_mul, op_sub, op_add} = op;
    k = 8'(ka);
    m = 8'(mb);
  endtask

  // Issue one op at the next negedge and wait for its DONE; latency counts the accept edge as 1.
  task automatic run_op(input string tag, input logic [4:0] op, input int ka, input int mb,
                        input int exp_r, input logic exp_ovf, input int lat_lo, input int lat_hi);
    int          lat;
    logic        got;
    logic [16:0] e;
    @(negedge clk);
    drive_op(op, ka, mb);
    start = 1'b1;
    exp_q.push_back({exp_ovf, 16'(exp_r)});
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= 400 && !got; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        check_eq({tag, "_busy"}, busy, 1);
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        lat = n;
      end
    end
    check_eq({tag, "_done"}, got, 1);
    e = exp_q.pop_front();
    if (got) begin
      check_eq({tag, "_r"}, r, e[15:0]);
      check_eq({tag, "_ovf"}, ovf, e[16]);
      check_eq({tag, "_busy_fin"}, busy, 0);
      if (lat_lo == lat_hi) check_eq({tag, "_lat"}, lat, lat_lo);
      else                  check_eq({tag, "_lat_in_range"}, (lat >= lat_lo) && (lat <= lat_hi), 1);
    end
  endtask

  initial begin
    int          ndone, first;
    logic [15:0] cap_r;
    logic        cap_ovf;
    logic [16:0] e;

    rst   = 1'b1;
    start = 1'b0;
    drive_op(5'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_r", r, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: each run_op issues START during the previous op's DONE cycle.
    run_op("add_100_27",    OP_ADD,  100,   27,    127, 1'b0,  3,   3);
    run_op("sub_m128_1",    OP_SUB, -128,    1,   -129, 1'b0,  3,   3);
    run_op("add_m128_m128", OP_ADD, -128, -128,   -256, 1'b0,  3,   3);
    run_op("mul_m128_m128", OP_MUL, -128, -128,  16384, 1'b0, 11,  11);
    run_op("mul_m128_127",  OP_MUL, -128,  127, -16256, 1'b0, 11,  11);
    run_op("mul_0_m5",      OP_MUL,    0,   -5,      0, 1'b0, 11,  11);
    run_op("div_m7_2",      OP_DIV,   -7,    2,     -3, 1'b0, 11,  11);
    run_op("div_m128_m1",   OP_DIV, -128,   -1,    128, 1'b0, 11,  11);
    run_op("div_7_0",       OP_DIV,    7,    0,      0, 1'b1,  1,  11);
    run_op("div_127_m10",   OP_DIV,  127,  -10,    -12, 1'b0, 11,  11);
    run_op("exp_2_14",      OP_EXP,    2,   14,  16384, 1'b0,  3, 143);
    run_op("exp_2_15",      OP_EXP,    2,   15,      0, 1'b1,  3, 153);
    run_op("exp_m2_15",     OP_EXP,   -2,   15, -32768, 1'b0,  3, 153);
    run_op("exp_m3_3",      OP_EXP,   -3,    3,    -27, 1'b0,  3,  33);
    run_op("exp_3_m1",      OP_EXP,    3,   -1,      0, 1'b0,  1,   3);
    run_op("exp_m1_m3",     OP_EXP,   -1,   -3,     -1, 1'b0,  1,   3);
    run_op("exp_m1_m4",     OP_EXP,   -1,   -4,      1, 1'b0,  1,   3);
    run_op("exp_0_0",       OP_EXP,    0,    0,      1, 1'b0,  1,   3);
    run_op("exp_0_m2",      OP_EXP,    0,   -2,      0, 1'b1,  1,   3);
    run_op("op_none",       5'b00000, 5,     5,      0, 1'b1,  3,   3);
    run_op("op_two",        OP_ADD | OP_MUL, 5, 5,   0, 1'b1,  3,   3);

    // START pulsed while a MUL is busy must be ignored.
    @(negedge clk);
    drive_op(OP_MUL, 5, 7);
    start = 1'b1;
    exp_q.push_back({1'b0, 16'd35});
    ndone   = 0;
    first   = 0;
    cap_r   = '0;
    cap_ovf = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) start = 1'b0;
      if (n == 3) begin
        drive_op(OP_ADD, 1, 1);
        start = 1'b1;
      end
      if (n == 4) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first   = n;
          cap_r   = r;
          cap_ovf = ovf;
        end
      end
    end
    e = exp_q.pop_front();
    check_eq("ign_done_count", ndone, 1);
    check_eq("ign_lat", first, 11);
    check_eq("ign_r", cap_r, e[15:0]);
    check_eq("ign_ovf", cap_ovf, e[16]);

    // Reset in the middle of a DIV aborts it without a DONE.
    @(negedge clk);
    drive_op(OP_DIV, 100, 3);
    start = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) start = 1'b0;
    end
    check_eq("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_r", r, 0);
    check_eq("abort_ovf", ovf, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_state", state, 0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check_eq("abort_no_done", ndone, 0);
    run_op("add_after_rst", OP_ADD, 3, 4, 7, 1'b0, 3, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
